// File: rtl/timer_multicanal.sv
// Multi-channel one-shot/periodic timer.
// Each channel: prescaled base tick, down-counter, registered pulse.
module timer_multicanal #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int PRESC = 25_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH-1:0]       stop,
  input  logic [N_CH-1:0]       modo,
  input  logic [N_CH*CNT_W-1:0] periodo,
  output logic [N_CH-1:0]       termino,
  output logic [N_CH-1:0]       activo
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESC - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           r_state, w_state_n;
    logic [PW-1:0]    r_presc, w_presc_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [CNT_W-1:0] r_per, w_per_n;
    logic [CNT_W-1:0] w_per_in;
    logic             r_modo, w_modo_n;
    logic             r_term, w_term_n;
    logic             w_tick, w_expire;
    logic             w_act, w_term;

    assign w_per_in = periodo[i*CNT_W +: CNT_W];
    assign w_tick   = (r_state == RUN) && (r_presc == PMAX);
    assign w_expire = w_tick && (r_cnt == CNT_W'(1));

    // State and datapath registers; reset clears everything.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= IDLE;
        r_presc <= '0;
        r_cnt   <= '0;
        r_per   <= '0;
        r_modo  <= 1'b0;
        r_term  <= 1'b0;
      end else begin
        r_state <= w_state_n;
        r_presc <= w_presc_n;
        r_cnt   <= w_cnt_n;
        r_per   <= w_per_n;
        r_modo  <= w_modo_n;
        r_term  <= w_term_n;
      end
    end

    // Next state: start beats stop, stop beats expiry.
    always_comb begin
      w_state_n = r_state;
      w_presc_n = r_presc;
      w_cnt_n   = r_cnt;
      w_per_n   = r_per;
      w_modo_n  = r_modo;
      w_term_n  = 1'b0;
      if (start[i]) begin
        if (w_per_in != '0) begin
          w_state_n = RUN;
          w_presc_n = '0;
          w_cnt_n   = w_per_in;
          w_per_n   = w_per_in;
          w_modo_n  = modo[i];
        end else begin
          w_state_n = IDLE;
        end
      end else if (stop[i]) begin
        w_state_n = IDLE;
      end else if (r_state == RUN) begin
        if (w_tick) w_presc_n = '0;
        else        w_presc_n = r_presc + 1'b1;
        if (w_expire) begin
          w_term_n = 1'b1;
          if (r_modo) w_cnt_n   = r_per;
          else        w_state_n = IDLE;
        end else if (w_tick) begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end
    end

    // Outputs straight from registers.
    always_comb begin
      w_act  = (r_state == RUN);
      w_term = r_term;
    end

    assign activo[i]  = w_act;
    assign termino[i] = w_term;
  end

endmodule

// File: tb/tb_timer_multicanal.sv
// Directed bench for timer_multicanal.
// PRESC=4, CNT_W=8, N_CH=4.
module tb_timer_multicanal;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  start, stop, modo;
  logic [31:0] periodo;
  logic [3:0]  termino, activo;
  int          checks = 0;
  int          errors = 0;

  timer_multicanal #(
    .N_CH (4),
    .CNT_W(8),
    .PRESC(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .stop   (stop),
    .modo   (modo),
    .periodo(periodo),
    .termino(termino),
    .activo (activo)
  );

  always #5 clk = ~clk;

  task automatic set_per(input int ch, input logic [7:0] v);
    periodo[ch*8 +: 8] = v;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (termino !== 4'b0 || activo !== 4'b0) begin
      errors++;
      $display("FAIL reset_hold termino=%b activo=%b required 0000/0000",
               termino, activo);
    end
    reset = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      checks++;
      if (termino !== 4'b0 || activo !== 4'b0) begin
        errors++;
        $display("FAIL reset_idle k=%0d termino=%b activo=%b required 0000/0000",
                 k, termino, activo);
      end
    end
  endtask

  task automatic test_one_shot();
    set_per(0, 3);
    modo[0]  = 1'b0;
    start[0] = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 0) start[0] = 1'b0;
      checks++;
      if (termino[0] !== (k == 12) || activo[0] !== (k < 12)) begin
        errors++;
        $display("FAIL one_shot k=%0d t=%b a=%b required t=%b a=%b",
                 k, termino[0], activo[0], k == 12, k < 12);
      end
    end
  endtask

  task automatic test_periodic();
    set_per(1, 2);
    modo[1]  = 1'b1;
    start[1] = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        start[1] = 1'b0;
        set_per(1, 7);
        modo[1] = 1'b0;
      end
      if (k == 19) stop[1] = 1'b1;
      if (k == 20) stop[1] = 1'b0;
      checks++;
      if (termino[1] !== (k == 8 || k == 16) || activo[1] !== (k < 20)) begin
        errors++;
        $display("FAIL periodic k=%0d t=%b a=%b required t=%b a=%b",
                 k, termino[1], activo[1], k == 8 || k == 16, k < 20);
      end
    end
  endtask

  task automatic test_restart();
    set_per(2, 5);
    modo[2]  = 1'b0;
    start[2] = 1'b1;
    for (int k = 0; k <= 35; k++) begin
      @(posedge clk); #1;
      if (k == 0)  start[2] = 1'b0;
      if (k == 9)  start[2] = 1'b1;
      if (k == 10) start[2] = 1'b0;
      checks++;
      if (termino[2] !== (k == 30) || activo[2] !== (k < 30)) begin
        errors++;
        $display("FAIL restart k=%0d t=%b a=%b required t=%b a=%b",
                 k, termino[2], activo[2], k == 30, k < 30);
      end
    end
  endtask

  task automatic test_stop_on_expiry();
    set_per(2, 2);
    modo[2]  = 1'b0;
    start[2] = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 0) start[2] = 1'b0;
      if (k == 7) stop[2] = 1'b1;
      if (k == 8) stop[2] = 1'b0;
      checks++;
      if (termino[2] !== 1'b0 || activo[2] !== (k < 8)) begin
        errors++;
        $display("FAIL stop_expiry k=%0d t=%b a=%b required t=0 a=%b",
                 k, termino[2], activo[2], k < 8);
      end
    end
  endtask

  task automatic test_start_on_expiry();
    set_per(0, 1);
    modo[0]  = 1'b0;
    start[0] = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 0) start[0] = 1'b0;
      if (k == 3) start[0] = 1'b1;
      if (k == 4) start[0] = 1'b0;
      checks++;
      if (termino[0] !== (k == 8) || activo[0] !== (k < 8)) begin
        errors++;
        $display("FAIL start_expiry k=%0d t=%b a=%b required t=%b a=%b",
                 k, termino[0], activo[0], k == 8, k < 8);
      end
    end
  endtask

  task automatic test_zero_period();
    set_per(3, 0);
    start[3] = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 0) start[3] = 1'b0;
      checks++;
      if (termino[3] !== 1'b0 || activo[3] !== 1'b0) begin
        errors++;
        $display("FAIL zero_period k=%0d t=%b a=%b required t=0 a=0",
                 k, termino[3], activo[3]);
      end
    end
  endtask

  task automatic test_concurrency();
    logic [3:0] et, ea;
    set_per(0, 1);   modo[0] = 1'b0;
    set_per(1, 1);   modo[1] = 1'b1;
    set_per(2, 0);   modo[2] = 1'b0;
    set_per(3, 255); modo[3] = 1'b0;
    start = 4'b1011;
    for (int k = 0; k <= 1025; k++) begin
      @(posedge clk); #1;
      if (k == 0) start = 4'b0000;
      et = {k == 1020, 1'b0, (k > 0) && (k % 4 == 0), k == 4};
      ea = {k < 1020, 1'b0, 1'b1, k < 4};
      checks++;
      if (termino !== et || activo !== ea) begin
        errors++;
        $display("FAIL concurrency k=%0d t=%b a=%b required t=%b a=%b",
                 k, termino, activo, et, ea);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] et, ea;
    start = 4'b1011;
    for (int k = 0; k <= 80; k++) begin
      @(posedge clk); #1;
      if (k == 0)  start = 4'b0000;
      if (k == 49) reset = 1'b1;
      if (k == 51) reset = 1'b0;
      if (k < 50) begin
        et = {1'b0, 1'b0, (k > 0) && (k % 4 == 0), k == 4};
        ea = {1'b1, 1'b0, 1'b1, k < 4};
      end else begin
        et = 4'b0000;
        ea = 4'b0000;
      end
      checks++;
      if (termino !== et || activo !== ea) begin
        errors++;
        $display("FAIL reset_mid_run k=%0d t=%b a=%b required t=%b a=%b",
                 k, termino, activo, et, ea);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = '0;
    stop    = '0;
    modo    = '0;
    periodo = '0;
    test_reset();
    test_one_shot();
    test_periodic();
    test_restart();
    test_stop_on_expiry();
    test_start_on_expiry();
    test_zero_period();
    test_concurrency();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
